// File: rtl/adc_32_pkg.sv
// Shared constants and the carry-lookahead helper for the adc_32 adder.
// The helper is used both inside each 4-bit group and across groups.
package adc_32_pkg;

    localparam int ADC_WIDTH  = 32;
    localparam int GROUP_SIZE = 4;

    // Carry into position n (0..4) of a 4-wide block, written as a flat
    // sum of products of generate/propagate terms rather than a ripple chain.
    function automatic logic lookahead_carry(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cin,
        input int         n
    );
        logic c;
        logic term;
        c = cin;
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                c = c & p[k];
            end
        end
        for (int m = 0; m < 4; m++) begin
            if (m < n) begin
                term = g[m];
                for (int q = 0; q < 4; q++) begin
                    if (q > m && q < n) begin
                        term = term & p[q];
                    end
                end
                c = c | term;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/adc_32_cla4.sv
// 4-bit carry-lookahead slice: local sum from an external carry-in plus
// group generate/propagate for the next lookahead level.
module cla4
    import adc_32_pkg::*;
(
    input  logic [GROUP_SIZE-1:0] a,
    input  logic [GROUP_SIZE-1:0] b,
    input  logic                  cin,
    output logic [GROUP_SIZE-1:0] s,
    output logic                  g,
    output logic                  p
);

    logic [GROUP_SIZE-1:0] gen;
    logic [GROUP_SIZE-1:0] prop;
    logic [GROUP_SIZE-1:0] carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    generate
        for (genvar gi = 0; gi < GROUP_SIZE; gi++) begin : g_carry
            assign carry[gi] = lookahead_carry(gen, prop, cin, gi);
        end
    endgenerate

    assign s = prop ^ carry;

    // Group terms depend only on a/b so the upper level never waits on cin.
    assign g = lookahead_carry(gen, prop, 1'b0, GROUP_SIZE);
    assign p = &prop;

endmodule

// File: rtl/adc_32.sv
// Registered WIDTH-bit adder with carry-in/carry-out built from cla4 groups,
// with a second lookahead level over blocks of four groups.
module adc_32
    import adc_32_pkg::*;
#(
    parameter int WIDTH = ADC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    localparam int NG  = WIDTH / GROUP_SIZE;
    localparam int NSG = (NG + 3) / 4;

    logic [NG-1:0]      g_grp;
    logic [NG-1:0]      p_grp;
    logic [NSG*4-1:0]   g_pad;
    logic [NSG*4-1:0]   p_pad;
    logic [NSG-1:0]     g_sg;
    logic [NSG-1:0]     p_sg;
    logic [NSG:0]       c_sg;
    logic [NSG*4:0]     c_grp;
    logic [WIDTH-1:0]   sum_next;
    logic               co_next;
    logic [WIDTH-1:0]   s_reg;
    logic               co_reg;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_slice
            cla4 u_cla4 (
                .a   (A[gi*GROUP_SIZE +: GROUP_SIZE]),
                .b   (B[gi*GROUP_SIZE +: GROUP_SIZE]),
                .cin (c_grp[gi]),
                .s   (sum_next[gi*GROUP_SIZE +: GROUP_SIZE]),
                .g   (g_grp[gi]),
                .p   (p_grp[gi])
            );
        end

        // Unused group slots above NG neither generate nor propagate.
        for (genvar gi = 0; gi < NSG*4; gi++) begin : g_pad_gen
            if (gi < NG) begin : g_real
                assign g_pad[gi] = g_grp[gi];
                assign p_pad[gi] = p_grp[gi];
            end else begin : g_fill
                assign g_pad[gi] = 1'b0;
                assign p_pad[gi] = 1'b0;
            end
        end

        for (genvar gi = 0; gi < NSG; gi++) begin : g_super
            assign g_sg[gi] = lookahead_carry(g_pad[gi*4 +: 4], p_pad[gi*4 +: 4], 1'b0, 4);
            assign p_sg[gi] = &p_pad[gi*4 +: 4];
            for (genvar gj = 0; gj < 4; gj++) begin : g_grp_carry
                assign c_grp[gi*4+gj] =
                    lookahead_carry(g_pad[gi*4 +: 4], p_pad[gi*4 +: 4], c_sg[gi], gj);
            end
        end
    endgenerate

    assign c_grp[NSG*4] = c_sg[NSG];

    // Block carries in sum-of-products form over the block generate/propagate.
    always_comb begin
        logic acc;
        logic term;
        acc  = 1'b0;
        term = 1'b0;
        c_sg = '0;
        c_sg[0] = C0;
        for (int k = 0; k < NSG; k++) begin
            acc = C0;
            for (int j = 0; j <= k; j++) begin
                acc = acc & p_sg[j];
            end
            for (int m = 0; m <= k; m++) begin
                term = g_sg[m];
                for (int q = m + 1; q <= k; q++) begin
                    term = term & p_sg[q];
                end
                acc = acc | term;
            end
            c_sg[k+1] = acc;
        end
    end

    assign co_next = c_grp[NG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg  <= '0;
            co_reg <= 1'b0;
        end else begin
            s_reg  <= sum_next;
            co_reg <= co_next;
        end
    end

    assign S  = s_reg;
    assign Co = co_reg;

endmodule

// File: tb/tb_adc_32.sv
// Randomised and directed bench for adc_32 against an arithmetic reference
// of A+B+C0 delayed by one clock.
module tb_adc_32;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C0;
    logic [W-1:0] S;
    logic         Co;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W:0]   exp_q;
    bit           exp_vld = 1'b0;
    string        exp_tag;

    always #5 clk = ~clk;

    adc_32 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .C0    (C0),
        .S     (S),
        .Co    (Co)
    );

    task automatic check_eq(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got {Co,S}=%h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Apply one vector at the falling edge; the previous vector's result is
    // checked just before and just after the inputs change.
    task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W:0] exp);
        @(negedge clk);
        if (exp_vld) check_eq(exp_tag, {Co, S}, exp_q);
        A  = a;
        B  = b;
        C0 = c;
        #2;
        if (exp_vld) check_eq({exp_tag, "_hold"}, {Co, S}, exp_q);
        $display("vec %s A=%h B=%h C0=%b exp=%h", tag, a, b, c, exp);
        exp_q   = exp;
        exp_vld = 1'b1;
        exp_tag = tag;
    endtask

    task automatic step_rand(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c);
        step(tag, a, b, c, ref_sum(a, b, c));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        A     = '1;
        B     = '1;
        C0    = 1'b1;

        // Outputs stay cleared while reset is held, whatever the inputs do.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("in_reset", {Co, S}, '0);
            A = $urandom;
            B = $urandom;
        end

        @(negedge clk);
        rst_n = 1'b1;

        step("zero",      32'h0000_0000, 32'h0000_0000, 1'b0, {1'b0, 32'h0000_0000});
        step("ff_ff_c0",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {1'b1, 32'hFFFF_FFFE});
        step("ff_ff_c1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b1, 32'hFFFF_FFFF});
        step("ff_00_c1",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b1, 32'h0000_0000});
        step("7f_01",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 32'h8000_0000});
        step("mixed",     32'h1234_5678, 32'h9ABC_DEF0, 1'b1, {1'b0, 32'hACF1_3569});

        // Asynchronous reset between edges while the output is nonzero.
        @(posedge clk);
        #3;
        check_eq(exp_tag, {Co, S}, exp_q);
        rst_n = 1'b0;
        #1;
        check_eq("async_clear", {Co, S}, '0);
        exp_vld = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset_held", {Co, S}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        A  = 32'h1234_5678;
        B  = 32'h0000_0001;
        C0 = 1'b0;
        #1;
        check_eq("no_stale", {Co, S}, '0);
        exp_q   = ref_sum(A, B, C0);
        exp_vld = 1'b1;
        exp_tag = "post_reset";

        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         c;
            a = pick_operand();
            b = pick_operand();
            c = 1'($urandom_range(0, 1));
            step_rand($sformatf("rnd%0d", i), a, b, c);
        end

        @(negedge clk);
        check_eq(exp_tag, {Co, S}, exp_q);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
